// File: rtl/rom_ctrl_exp_digest_loader.sv
// Expected-digest loader: reads the top NumWords ROM words into the EXP_DIGEST image,
// then kicks the digest comparator once. Consistency violations drive a fatal alert.
module rom_ctrl_exp_digest_loader #(
    parameter int NumWords = 8,
    parameter int RomDepth = 8192,
    parameter int AddrW    = (RomDepth > 1) ? $clog2(RomDepth) : 1,
    parameter int IdxW     = (NumWords > 1) ? $clog2(NumWords) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    output logic                   rom_req_o,
    output logic [AddrW-1:0]       rom_addr_o,
    input  logic                   rom_gnt_i,
    input  logic                   rom_rvalid_i,
    input  logic [31:0]            rom_rdata_i,
    output logic [NumWords*32-1:0] exp_digest_o,
    output logic                   done_o,
    output logic                   cmp_start_o,
    output logic                   alert_o
);

    // Pairwise Hamming distance >= 3 between all legal encodings.
    typedef enum logic [4:0] {
        Idle = 5'b10110,
        Req  = 5'b01101,
        Wait = 5'b11011,
        Done = 5'b00000
    } state_e;

    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NumWords - 1);
    localparam logic [AddrW-1:0] BaseAddr = AddrW'(RomDepth - NumWords);

    logic [4:0]                 state_q, state_d;
    logic [IdxW-1:0]            idx_q, idx_inv_q;
    logic [NumWords-1:0][31:0]  digest_q;
    logic                       cmp_done_q;
    logic                       idx_inc, digest_we;
    logic                       fsm_alert, start_alert, rvalid_alert;
    logic                       idle_idx_alert, done_idx_alert, cnt_err;

    always_comb begin
        state_d   = state_q;
        rom_req_o = 1'b0;
        fsm_alert = 1'b0;
        idx_inc   = 1'b0;
        digest_we = 1'b0;
        case (state_q)
            Idle: if (start_i) state_d = Req;
            Req: begin
                rom_req_o = 1'b1;
                if (rom_gnt_i) state_d = Wait;
            end
            Wait: begin
                if (rom_rvalid_i) begin
                    digest_we = 1'b1;
                    if (idx_q == LastIdx) begin
                        state_d = Done;
                    end else begin
                        idx_inc = 1'b1;
                        state_d = Req;
                    end
                end
            end
            Done: ;
            // Illegal encoding: hold the state so the alert stays asserted.
            default: fsm_alert = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= Idle;
            idx_q      <= '0;
            idx_inv_q  <= '1;
            digest_q   <= '0;
            cmp_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (idx_inc) begin
                idx_q     <= idx_q + 1'b1;
                idx_inv_q <= idx_inv_q - 1'b1;
            end
            if (digest_we) digest_q[idx_q] <= rom_rdata_i;
            cmp_done_q <= (state_q == Done);
        end
    end

    // Counter is kept together with its complement; any disagreement is a fault.
    assign cnt_err        = (idx_q != ~idx_inv_q);
    assign start_alert    = start_i && (state_q != Idle);
    assign rvalid_alert   = rom_rvalid_i && (state_q != Wait);
    assign idle_idx_alert = (state_q == Idle) && (idx_q != '0);
    assign done_idx_alert = (state_q == Done) && (idx_q != LastIdx);

    assign alert_o = fsm_alert | start_alert | rvalid_alert |
                     idle_idx_alert | done_idx_alert | cnt_err;

    assign rom_addr_o   = rom_req_o ? (BaseAddr + AddrW'(idx_q)) : '0;
    assign exp_digest_o = digest_q;
    assign done_o       = (state_q == Done);
    assign cmp_start_o  = (state_q == Done) && !cmp_done_q;

endmodule

// File: tb/tb_rom_ctrl_exp_digest_loader.sv
// Directed bench: a 2-word/16-deep instance for protocol corners and a default-sized one.
module tb_rom_ctrl_exp_digest_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Small instance: NumWords=2, RomDepth=16
    logic        start = 0, gnt = 0, rvalid = 0;
    logic [31:0] rdata = '0;
    logic        req, done, cmp, alert;
    logic [3:0]  addr;
    logic [63:0] dig;

    rom_ctrl_exp_digest_loader #(.NumWords(2), .RomDepth(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .rom_req_o(req), .rom_addr_o(addr), .rom_gnt_i(gnt),
        .rom_rvalid_i(rvalid), .rom_rdata_i(rdata),
        .exp_digest_o(dig), .done_o(done), .cmp_start_o(cmp), .alert_o(alert)
    );

    // Default-parameter instance
    logic         start8 = 0, gnt8 = 0, rvalid8 = 0;
    logic [31:0]  rdata8 = '0;
    logic         req8, done8, cmp8, alert8;
    logic [12:0]  addr8;
    logic [255:0] dig8;

    rom_ctrl_exp_digest_loader dut8 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start8),
        .rom_req_o(req8), .rom_addr_o(addr8), .rom_gnt_i(gnt8),
        .rom_rvalid_i(rvalid8), .rom_rdata_i(rdata8),
        .exp_digest_o(dig8), .done_o(done8), .cmp_start_o(cmp8), .alert_o(alert8)
    );

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0; start = 0; gnt = 0; rvalid = 0; rdata = '0;
        start8 = 0; gnt8 = 0; rvalid8 = 0; rdata8 = '0;
        nxt(); nxt();
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++;
        if ({req, addr, done, cmp, alert, dig} !== '0) begin
            n_fail++; $display("FAIL reset_small: got req=%b addr=%0d done=%b cmp=%b alert=%b dig=%h exp all 0",
                               req, addr, done, cmp, alert, dig);
        end
        n_tests++;
        if ({req8, addr8, done8, cmp8, alert8, dig8} !== '0) begin
            n_fail++; $display("FAIL reset_default: got req=%b addr=%0d done=%b cmp=%b alert=%b exp all 0",
                               req8, addr8, done8, cmp8, alert8);
        end
        nxt();
    endtask

    task automatic test_basic();
        logic alert_any;
        do_reset();
        alert_any = 0;
        start = 1; #1;
        n_tests++;
        if (req !== 1'b0) begin n_fail++; $display("FAIL basic_c0_req: got %b exp 0", req); end
        alert_any |= alert; nxt();
        start = 0; gnt = 1; #1;
        n_tests++;
        if (req !== 1'b1 || addr !== 4'd14) begin
            n_fail++; $display("FAIL basic_c1_addr: got req=%b addr=%0d exp req=1 addr=14", req, addr);
        end
        alert_any |= alert; nxt();
        gnt = 0; rvalid = 1; rdata = 32'hA5A5_0001; #1;
        n_tests++;
        if (req !== 1'b0 || addr !== 4'd0) begin
            n_fail++; $display("FAIL basic_c2_wait: got req=%b addr=%0d exp req=0 addr=0", req, addr);
        end
        alert_any |= alert; nxt();
        rvalid = 0; gnt = 1; #1;
        n_tests++;
        if (req !== 1'b1 || addr !== 4'd15) begin
            n_fail++; $display("FAIL basic_c3_addr: got req=%b addr=%0d exp req=1 addr=15", req, addr);
        end
        n_tests++;
        if (dig[31:0] !== 32'hA5A5_0001) begin
            n_fail++; $display("FAIL basic_word0: got %h exp a5a50001", dig[31:0]);
        end
        alert_any |= alert; nxt();
        gnt = 0; rvalid = 1; rdata = 32'h5A5A_0002; #1;
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL basic_c4_done: got %b exp 0", done); end
        alert_any |= alert; nxt();
        rvalid = 0; #1;
        n_tests++;
        if (done !== 1'b1 || cmp !== 1'b1) begin
            n_fail++; $display("FAIL basic_c5_done: got done=%b cmp=%b exp 1 1", done, cmp);
        end
        n_tests++;
        if (dig !== 64'h5A5A0002_A5A50001) begin
            n_fail++; $display("FAIL basic_digest: got %h exp 5a5a0002a5a50001", dig);
        end
        alert_any |= alert; nxt();
        #1;
        n_tests++;
        if (cmp !== 1'b0 || done !== 1'b1) begin
            n_fail++; $display("FAIL basic_c6_pulse: got cmp=%b done=%b exp 0 1", cmp, done);
        end
        alert_any |= alert;
        n_tests++;
        if (alert_any !== 1'b0) begin n_fail++; $display("FAIL basic_alert: got %b exp 0", alert_any); end
        nxt();
    endtask

    task automatic test_default_params();
        logic [255:0] exp8;
        do_reset();
        exp8 = '0;
        start8 = 1; nxt();
        start8 = 0;
        for (int w = 0; w < 8; w++) begin
            for (int d = 0; d < 3; d++) begin
                gnt8 = 0; #1;
                n_tests++;
                if (req8 !== 1'b1 || addr8 !== 13'(8184 + w)) begin
                    n_fail++; $display("FAIL dflt_stall w%0d d%0d: got req=%b addr=%0d exp req=1 addr=%0d",
                                       w, d, req8, addr8, 8184 + w);
                end
                nxt();
            end
            gnt8 = 1; #1;
            n_tests++;
            if (req8 !== 1'b1 || addr8 !== 13'(8184 + w)) begin
                n_fail++; $display("FAIL dflt_gnt w%0d: got req=%b addr=%0d exp req=1 addr=%0d",
                                   w, req8, addr8, 8184 + w);
            end
            nxt();
            gnt8 = 0; rvalid8 = 1; rdata8 = 32'hC0DE_0000 | 32'(w);
            exp8[32*w +: 32] = rdata8;
            #1;
            n_tests++;
            if (done8 !== 1'b0) begin n_fail++; $display("FAIL dflt_early_done w%0d: got %b exp 0", w, done8); end
            nxt();
            rvalid8 = 0;
        end
        #1;
        n_tests++;
        if (done8 !== 1'b1 || cmp8 !== 1'b1 || alert8 !== 1'b0) begin
            n_fail++; $display("FAIL dflt_done: got done=%b cmp=%b alert=%b exp 1 1 0", done8, cmp8, alert8);
        end
        n_tests++;
        if (dig8 !== exp8) begin n_fail++; $display("FAIL dflt_digest: got %h exp %h", dig8, exp8); end
        nxt();
    endtask

    task automatic test_start_in_wait();
        do_reset();
        start = 1; nxt();
        start = 0; gnt = 1; nxt();
        gnt = 0; start = 1; rvalid = 1; rdata = 32'h1111_1111; #1;
        n_tests++;
        if (alert !== 1'b1) begin n_fail++; $display("FAIL siw_alert: got %b exp 1", alert); end
        nxt();
        start = 0; rvalid = 0; gnt = 1; nxt();
        gnt = 0; rvalid = 1; rdata = 32'h2222_2222; nxt();
        rvalid = 0; #1;
        n_tests++;
        if (done !== 1'b1 || dig !== 64'h22222222_11111111) begin
            n_fail++; $display("FAIL siw_complete: got done=%b dig=%h exp 1 2222222211111111", done, dig);
        end
        nxt();
    endtask

    task automatic test_spurious_rvalid();
        do_reset();
        rvalid = 1; rdata = 32'hDEAD_BEEF; #1;
        n_tests++;
        if (alert !== 1'b1) begin n_fail++; $display("FAIL sprv_idle_alert: got %b exp 1", alert); end
        nxt();
        rvalid = 0; #1;
        n_tests++;
        if (dig !== 64'd0 || alert !== 1'b0) begin
            n_fail++; $display("FAIL sprv_idle_dig: got dig=%h alert=%b exp 0 0", dig, alert);
        end
        start = 1; nxt();
        start = 0; gnt = 1; rvalid = 1; #1;
        n_tests++;
        if (alert !== 1'b1) begin n_fail++; $display("FAIL sprv_gnt_alert: got %b exp 1", alert); end
        nxt();
        gnt = 0; rvalid = 0; #1;
        n_tests++;
        if (dig !== 64'd0) begin n_fail++; $display("FAIL sprv_gnt_dig: got %h exp 0", dig); end
        nxt();
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        start = 1; nxt();
        start = 0; gnt = 1; nxt();
        gnt = 0; rvalid = 1; rdata = 32'hAAAA_0000; nxt();
        rvalid = 0; gnt = 1; nxt();
        gnt = 0; rst_n = 0; nxt();
        rst_n = 1; rvalid = 1; rdata = 32'hBBBB_0000; #1;
        n_tests++;
        if (alert !== 1'b1) begin n_fail++; $display("FAIL rmf_late_rvalid: got %b exp 1", alert); end
        n_tests++;
        if ({req, addr, done, cmp, dig} !== '0) begin
            n_fail++; $display("FAIL rmf_outputs: got req=%b addr=%0d done=%b cmp=%b dig=%h exp all 0",
                               req, addr, done, cmp, dig);
        end
        nxt();
        rvalid = 0; start = 1; nxt();
        start = 0; gnt = 1; #1;
        n_tests++;
        if (req !== 1'b1 || addr !== 4'd14) begin
            n_fail++; $display("FAIL rmf_restart_addr: got req=%b addr=%0d exp 1 14", req, addr);
        end
        nxt();
        gnt = 0; rvalid = 1; rdata = 32'hCCCC_0000; nxt();
        rvalid = 0; gnt = 1; nxt();
        gnt = 0; rvalid = 1; rdata = 32'hDDDD_0001; nxt();
        rvalid = 0; #1;
        n_tests++;
        if (done !== 1'b1 || dig !== 64'hDDDD0001_CCCC0000 || alert !== 1'b0) begin
            n_fail++; $display("FAIL rmf_refetch: got done=%b dig=%h alert=%b exp 1 dddd0001cccc0000 0",
                               done, dig, alert);
        end
        nxt();
    endtask

    task automatic test_bad_state();
        do_reset();
        force dut.state_q = 5'b11111;
        #1;
        n_tests++;
        if (alert !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL bad_state_now: got alert=%b done=%b exp 1 0", alert, done);
        end
        nxt(); nxt(); #1;
        n_tests++;
        if (alert !== 1'b1 || done !== 1'b0 || req !== 1'b0) begin
            n_fail++; $display("FAIL bad_state_held: got alert=%b done=%b req=%b exp 1 0 0", alert, done, req);
        end
        release dut.state_q;
        do_reset();
    endtask

    initial begin
        nxt();
        test_reset();
        test_basic();
        test_default_params();
        test_start_in_wait();
        test_spurious_rvalid();
        test_reset_mid_fetch();
        test_bad_state();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, exp finished");
        $fatal(1, "watchdog expired");
    end

endmodule
